// File: rtl/ir_cmd_packetizer_if.sv
// Byte stream from the IR command packetizer to uart_tx.
// The master holds tx_data stable while tx_valid is high and tx_ready is low.
interface ir_cmd_packetizer_if;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/ir_cmd_packetizer.sv
// IR command packetizer: turns decoded NEC frames into robot command bytes.
// Flow: frame edge detect -> integrity check and key map -> repeat suppression
// -> small first-word-fall-through FIFO -> uart_tx handshake.
// A STOP byte is injected once the link has been silent for STOP_TIMEOUT cycles.
module ir_cmd_packetizer #(
    parameter int         DEPTH        = 4,
    parameter int         REPEAT_GAP   = 5_000_000,
    parameter int         STOP_TIMEOUT = 25_000_000,
    parameter logic [7:0] STOP_BYTE    = 8'h01
) (
    input  logic                iCLK,
    input  logic                iRST_n,
    input  logic                iDATA_READY,
    input  logic [31:0]         iDATA,
    ir_cmd_packetizer_if.master tx,
    output logic [7:0]          last_cmd,
    output logic [7:0]          drop_count,
    output logic                fifo_full
);
    localparam int AW       = $clog2(DEPTH);
    localparam int GAP_MAX  = (REPEAT_GAP > 0)   ? REPEAT_GAP   : 1;
    localparam int IDLE_MAX = (STOP_TIMEOUT > 0) ? STOP_TIMEOUT : 1;
    localparam int GAP_W    = $clog2(GAP_MAX + 1);
    localparam int IDLE_W   = $clog2(IDLE_MAX + 1);

    logic              rdy_d;
    logic              frame_evt;
    logic [7:0]        key_code;
    logic [7:0]        key_inv;
    logic [7:0]        map_byte;
    logic              map_hit;
    logic              s1_ok;
    logic [7:0]        s1_byte;
    logic [GAP_W-1:0]  gap_cnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic              frame_push;
    logic              timeout_push;
    logic              push;
    logic [7:0]        push_byte;
    logic [7:0]        mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              empty;
    logic              full;
    logic              pop;
    logic              wr_en;
    logic              drop;
    logic              unused_low;

    // The low address half of the NEC frame carries nothing this block needs.
    assign unused_low = ^iDATA[15:0];

    assign key_code  = iDATA[23:16];
    assign key_inv   = iDATA[31:24];
    assign frame_evt = iDATA_READY & ~rdy_d;

    // Remote key to robot command byte lookup.
    always_comb begin
        // NOTE: defaults first, so every path assigns both outputs and no latch is inferred.
        map_hit  = 1'b1;
        map_byte = 8'h00;
        case (key_code)
            8'h00:   map_byte = 8'h01;
            8'h02:   map_byte = 8'h02;
            8'h04:   map_byte = 8'h08;
            8'h05:   map_byte = 8'h10;
            8'h06:   map_byte = 8'h20;
            8'h08:   map_byte = 8'h80;
            default: map_hit  = 1'b0;
        endcase
    end

    // Edge register and stage 1: capture one checked, mapped byte per new frame.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            rdy_d   <= 1'b0;
            s1_ok   <= 1'b0;
            s1_byte <= 8'h00;
        end else begin
            // NOTE: non-blocking, so frame_evt above is formed from last cycle's rdy_d.
            rdy_d <= iDATA_READY;
            s1_ok <= frame_evt & map_hit & (key_code == ~key_inv);
            if (frame_evt) begin
                s1_byte <= map_byte;
            end
        end
    end

    // Stage 2: a new key, or the same key after a long enough gap, is pushed.
    // The STOP timeout fires once per silence and yields to any good frame.
    assign frame_push   = s1_ok && ((s1_byte != last_cmd) || (gap_cnt >= GAP_W'(REPEAT_GAP)));
    assign timeout_push = (STOP_TIMEOUT != 0) && !s1_ok &&
                          (idle_cnt == IDLE_W'(IDLE_MAX - 1)) &&
                          (last_cmd != STOP_BYTE) && (last_cmd != 8'h00);
    assign push         = frame_push | timeout_push;
    assign push_byte    = frame_push ? s1_byte : STOP_BYTE;

    // Gap and idle counters: saturating, cleared by every good frame.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            gap_cnt  <= '0;
            idle_cnt <= '0;
        end else if (s1_ok) begin
            gap_cnt  <= '0;
            idle_cnt <= '0;
        end else begin
            if (gap_cnt < GAP_W'(GAP_MAX)) begin
                gap_cnt <= gap_cnt + GAP_W'(1);
            end
            if (idle_cnt < IDLE_W'(IDLE_MAX)) begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
            end
        end
    end

    // Last pushed byte (kept even when the FIFO drops it) and saturating drop counter.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            last_cmd   <= 8'h00;
            drop_count <= 8'h00;
        end else begin
            if (push) begin
                last_cmd <= push_byte;
            end
            if (drop && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = !empty && tx.tx_ready;
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    // FIFO storage write port.
    always_ff @(posedge iCLK) begin
        // NOTE: storage is not reset; reset empties the FIFO and tx_data is masked while empty.
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= push_byte;
        end
    end

    // FIFO pointers with an extra wrap bit to tell full from empty.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    assign tx.tx_valid = !empty;
    assign tx.tx_data  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
    assign fifo_full   = full;
endmodule

// File: doc/ir_cmd_packetizer.md
Name: ir_cmd_packetizer

Overview:
- Sits between the IR_RECEIVE NEC decoder and uart_tx in the robot controller.
- Detects each new decoded frame and checks it with the command/inverse-command pair.
- Maps remote keys to robot command bytes, suppresses key-repeat floods and queues bytes in a small FIFO.
- Drains the FIFO to uart_tx over a valid/ready handshake, and injects a STOP byte when the link goes silent.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >=2.
- REPEAT_GAP, 5_000_000, cycles within which an identical command is suppressed (100 ms at 50 MHz).
- STOP_TIMEOUT, 25_000_000, idle cycles after the last accepted motion command before STOP is queued; 0 disables.
- STOP_BYTE, 8'h01, byte queued on timeout.

Ports:
- iCLK  input  1  system clock, 50 MHz, shared with IR_RECEIVE and uart_tx.
- iRST_n  input  1  asynchronous active-low reset.
- iDATA_READY  input  1  IR_RECEIVE oDATA_READY; a level, synchronous to iCLK.
- iDATA  input  32  IR_RECEIVE oDATA; [23:16]=key code, [31:24]=inverted key code.
- tx_valid  output  1  FIFO non-empty.
- tx_ready  input  1  uart_tx ready.
- tx_data  output  8  FIFO head byte.
- last_cmd  output  8  last byte pushed; STOP_BYTE after a timeout.
- drop_count  output  8  saturating count of bytes lost to a full FIFO.
- fifo_full  output  1  FIFO full flag.

Behaviour:
- Clock and reset: one clock, iCLK. Reset is asynchronous and active-low on iRST_n. Asserting it clears everything immediately:
  - all outputs, tx_data included, go to 0;
  - FIFO becomes empty;
  - counters go to 0;
  - edge register goes to 0.
  Reset mid-transfer discards queued bytes. No byte is emitted until a new frame arrives after reset.
- Edge detect:
  - rdy_d <= iDATA_READY.
  - frame_evt = iDATA_READY & ~rdy_d.
  - A level held high produces exactly one event.
- Stage 1 (edge after frame_evt):
  - Capture iDATA[31:16].
  - s1_ok = (code == ~inv) and code is in the map:
    - 0x00 -> 0x01
    - 0x02 -> 0x02
    - 0x04 -> 0x08
    - 0x05 -> 0x10
    - 0x06 -> 0x20
    - 0x08 -> 0x80
  - Invalid or unmapped frames are ignored entirely: no push, and counters are untouched.
- Stage 2 (next edge):
  - If s1_ok and (byte != last_cmd or gap_cnt >= REPEAT_GAP): push the byte, last_cmd <= byte.
  - Any s1_ok frame, pushed or suppressed, resets gap_cnt and idle_cnt to 0.
  - Latency: frame_evt in cycle N gives tx_valid=1 in cycle N+2, provided the FIFO was empty.
- Counters: gap_cnt and idle_cnt increment every cycle and saturate at their terminal values (no wrap).
- Timeout:
  - Condition: STOP_TIMEOUT != 0, idle_cnt == STOP_TIMEOUT-1, last_cmd != STOP_BYTE and last_cmd != 0.
  - Action: push STOP_BYTE once, last_cmd <= STOP_BYTE.
- Simultaneous frame and timeout push in the same cycle: the frame push wins, the timeout is cancelled and idle_cnt resets.
- FIFO:
  - First-word-fall-through; tx_data = head; tx_valid = !empty.
  - Pop when tx_valid & tx_ready.
  - Push while full with no pop in the same cycle: byte dropped, drop_count++ (saturates at 255), last_cmd still updated.
  - Push and pop in the same cycle while full: both occur, occupancy unchanged.
  - Push and pop in the same cycle while empty: not possible, because the head is not valid yet; the push lands and tx_valid rises next cycle.
  - Pointers wrap modulo DEPTH; full/empty use an extra pointer bit.
- Handshake: tx_data stays stable while tx_valid=1 and tx_ready=0.

Test Plan:
- Basic push:
  - Stimulus: reset, then iDATA[31:16]=16'hFD02, iDATA_READY rises for 1 cycle.
  - Response: tx_valid=1 two cycles later with tx_data=8'h02, last_cmd=8'h02; byte popped on the first tx_ready=1.
- Level hold and integrity check:
  - Stimulus: iDATA_READY held high for 50 cycles with 16'hFB04; then 16'hFA04 (bad inverse); then 16'hEE11 (valid but unmapped).
  - Response: exactly one 8'h08 queued for the first; nothing queued for the other two.
- Repeat suppression (REPEAT_GAP=100):
  - Stimulus: key 6 (16'hF906) frames 50 cycles apart.
  - Response: only the first 8'h20 is queued.
  - Stimulus: same frame repeated 150 cycles after the last one.
  - Response: a second 8'h20 is queued.
- Overflow (DEPTH=4, tx_ready=0):
  - Stimulus: six alternating frames, key 2 and key 8.
  - Response: fifo_full=1, drop_count=2, FIFO holds 02,80,02,80 in that order.
  - Stimulus: then tx_ready=1.
  - Response: the four bytes drain in order.
- Timeout (STOP_TIMEOUT=1000):
  - Stimulus: key 5 frame, then silence.
  - Response: 8'h10 queued, then a single 8'h01 queued 1000 cycles after the frame; no further bytes.
  - Stimulus: key 5 frame landing on the timeout cycle instead.
  - Response: only 8'h10 is queued.
- Reset mid-operation:
  - Stimulus: iRST_n low while 3 bytes are queued and tx_valid=1.
  - Response: tx_valid, tx_data, last_cmd and drop_count are 0 immediately, without waiting for a clock edge.
  - Stimulus: release reset.
  - Response: nothing is emitted until the next frame_evt.
